serial_add_ctrl: RTL

//   Bit-serial adder sequencer: captures two WIDTH-bit operands on a start request,

---
 rtl/serial_add_pkg.sv | 14 +
 rtl/serial_add_ctrl_ha_cell.sv | 12 +
 rtl/serial_add_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder sequencer: FSM state encoding and
// the legal range of the operand width.
package serial_add_pkg;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_ha_cell.sv
// Half-adder cell; two of these plus an OR gate form the shared 1-bit full adder.
module ha_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: LSB-first over WIDTH cycles with a busy/done handshake.
// Define SERIAL_ADD_SUB_EN to add a `sub` input that turns the operation into a - b.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   a_sh, b_sh, res_sh, res_nxt;
    logic [WIDTH-1:0]   b_load;
    logic               carry, cin;
    logic [CNT_W-1:0]   cnt;
    logic               accept, last_bit;
    logic               s1, c1, fa_s, c2, fa_c;

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction is a + ~b + 1; cout then reads as "no borrow".
    assign b_load = sub ? ~b : b;
    assign cin    = sub;
`else
    assign b_load = b;
    assign cin    = 1'b0;
`endif

    assign accept   = (state == ST_IDLE) && start;
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    ha_cell u_ha_lo (.a(a_sh[0]), .b(b_sh[0]), .s(s1),   .c(c1));
    ha_cell u_ha_hi (.a(s1),      .b(carry),   .s(fa_s), .c(c2));
    assign fa_c = c1 | c2;

    // New sum bit enters at the MSB so the LSB-first result lands in place after WIDTH shifts.
    assign res_nxt = (res_sh >> 1) | {fa_s, {(WIDTH-1){1'b0}}};

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: state_nxt gets its default before the case so no path leaves it unassigned
    // (which would infer a latch).
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start)    state_nxt = ST_RUN;
            ST_RUN:  if (last_bit) state_nxt = ST_DONE;
            ST_DONE:               state_nxt = ST_IDLE;
            default:               state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b_load;
            carry  <= cin;
            cnt    <= '0;
        end else if (state == ST_RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_nxt;
            carry  <= fa_c;
            if (last_bit) begin
                sum  <= res_nxt;
                cout <= fa_c;
                cnt  <= '0;
            end else begin
                cnt  <= cnt + 1'b1;
            end
        end
    end

endmodule
